// File: rtl/rx_path_ddr_writer.sv
// rx_path_ddr_writer: one S2MM command per write, 64->128 payload packing, DataMover status to done/error.
// Latency: input word to registered output beat in one cycle; command/status handshakes are registered off the FSM.
// Backpressure: payload tready drops only while the single output beat is held by a stalled DataMover; RX_WR_TIMEOUT_EN adds a status timeout.
module rx_path_ddr_writer #(
  parameter int IN_WIDTH       = 64,
  parameter int AXI_FRAME_SIZE = 128
`ifdef RX_WR_TIMEOUT_EN
  ,
  parameter int STS_TIMEOUT    = 4096
`endif
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [31:0]                 cmd_dst_addr,
  input  logic [31:0]                 cmd_mem_length,
  input  logic                        cmd_valid,
  output logic                        cmd_ready,
  output logic                        transfer_done,
  output logic                        xfer_error,
  output logic                        busy,
  output logic [71:0]                 m_axis_s2mm_cmd_tdata,
  output logic                        m_axis_s2mm_cmd_tvalid,
  input  logic                        m_axis_s2mm_cmd_tready,
  input  logic [IN_WIDTH-1:0]         s_axis_tdata,
  input  logic                        s_axis_tvalid,
  output logic                        s_axis_tready,
  input  logic                        s_axis_tlast,
  output logic [AXI_FRAME_SIZE-1:0]   m_axis_s2mm_tdata,
  output logic [AXI_FRAME_SIZE/8-1:0] m_axis_s2mm_tkeep,
  output logic                        m_axis_s2mm_tvalid,
  input  logic                        m_axis_s2mm_tready,
  output logic                        m_axis_s2mm_tlast,
  input  logic [7:0]                  s_axis_s2mm_sts_tdata,
  input  logic                        s_axis_s2mm_sts_tvalid,
  output logic                        s_axis_s2mm_sts_tready
`ifdef RX_WR_TIMEOUT_EN
  ,
  output logic                        sts_timeout
`endif
);

  localparam int KEEP_W = AXI_FRAME_SIZE / 8;
  localparam logic [23:0] WORD_BYTES = 24'(IN_WIDTH / 8);
  localparam logic [KEEP_W-1:0] KEEP_FULL = {KEEP_W{1'b1}};
  localparam logic [KEEP_W-1:0] KEEP_HALF = {{(KEEP_W/2){1'b0}}, {(KEEP_W/2){1'b1}}};

  typedef enum logic [2:0] {IDLE, SEND_CMD, STREAM, WAIT_STS, DONE} state_t;

  state_t              state;
  state_t              state_nxt;
  logic [31:0]         addr_q;
  logic [22:0]         len_q;
  logic [22:0]         cnt_q;
  logic [23:0]         cnt_sum;
  logic [22:0]         cnt_nxt;
  logic                len_err_q;
  logic [IN_WIDTH-1:0] hold_q;
  logic                half_q;     // hold_q carries word 0 of the current beat
  logic                in_open_q;  // payload for this transfer is still expected
  logic                drop_q;     // length reached early, discarding until input tlast
  logic                last_sent_q;
  logic                in_acc;
  logic                out_fire;
  logic                sts_fire;
  logic                hit_len;
  logic                end_w;
  logic                tail_sent;
  logic                in_closed;
  logic                stream_exit;
  logic                tmo_hit;
  logic                done_err;
  logic                unused_bits;

  // Upper length bits and status detail bits carry no meaning for this block.
  assign unused_bits = ^{cmd_mem_length[31:23], s_axis_s2mm_sts_tdata[6:0]};

  assign m_axis_s2mm_cmd_tdata = {8'h00, addr_q, 1'b0, 1'b1, 6'h00, 1'b1, len_q};

  assign s_axis_tready = (state == STREAM) && in_open_q &&
                         (drop_q || !m_axis_s2mm_tvalid || m_axis_s2mm_tready);
  assign in_acc   = s_axis_tvalid && s_axis_tready;
  assign out_fire = m_axis_s2mm_tvalid && m_axis_s2mm_tready;
  assign sts_fire = s_axis_s2mm_sts_tvalid && s_axis_s2mm_sts_tready;

  // Byte counter saturates instead of wrapping.
  assign cnt_sum = {1'b0, cnt_q} + WORD_BYTES;
  assign cnt_nxt = cnt_sum[23] ? {23{1'b1}} : cnt_sum[22:0];
  assign hit_len = (cnt_nxt == len_q);
  assign end_w   = s_axis_tlast || hit_len;

  // STREAM ends once the tlast beat has gone out and no more payload belongs to this transfer.
  assign tail_sent   = last_sent_q || (out_fire && m_axis_s2mm_tlast);
  assign in_closed   = !in_open_q || (in_acc && drop_q && s_axis_tlast);
  assign stream_exit = tail_sent && in_closed;

  assign done_err = sts_fire ? (!s_axis_s2mm_sts_tdata[7] || len_err_q) : 1'b1;

`ifdef RX_WR_TIMEOUT_EN
  localparam int TMO_W = $clog2(STS_TIMEOUT + 1);
  logic [TMO_W-1:0] tmo_cnt_q;

  assign tmo_hit = (state == WAIT_STS) && (tmo_cnt_q == TMO_W'(STS_TIMEOUT - 1));

  // Status wait counter, restarted every time WAIT_STS is entered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt_q <= '0;
    end else if (state == WAIT_STS) begin
      tmo_cnt_q <= tmo_cnt_q + 1'b1;
    end else begin
      tmo_cnt_q <= '0;
    end
  end
`else
  assign tmo_hit = 1'b0;
`endif

  // Next-state decode.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (cmd_valid) state_nxt = SEND_CMD;
      SEND_CMD: if (m_axis_s2mm_cmd_tvalid && m_axis_s2mm_cmd_tready) state_nxt = STREAM;
      STREAM:   if (stream_exit) state_nxt = WAIT_STS;
      WAIT_STS: if (sts_fire || tmo_hit) state_nxt = DONE;
      DONE:     state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // State register, command latch and registered control outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state                  <= IDLE;
      addr_q                 <= '0;
      len_q                  <= '0;
      cmd_ready              <= 1'b1;
      busy                   <= 1'b0;
      m_axis_s2mm_cmd_tvalid <= 1'b0;
      s_axis_s2mm_sts_tready <= 1'b0;
      transfer_done          <= 1'b0;
      xfer_error             <= 1'b0;
`ifdef RX_WR_TIMEOUT_EN
      sts_timeout            <= 1'b0;
`endif
    end else begin
      state                  <= state_nxt;
      cmd_ready              <= (state_nxt == IDLE);
      busy                   <= (state_nxt != IDLE);
      m_axis_s2mm_cmd_tvalid <= (state_nxt == SEND_CMD);
      s_axis_s2mm_sts_tready <= (state_nxt == WAIT_STS);
      transfer_done          <= (state_nxt == DONE);
      xfer_error             <= (state == WAIT_STS) && (state_nxt == DONE) && done_err;
`ifdef RX_WR_TIMEOUT_EN
      sts_timeout            <= (state == WAIT_STS) && (state_nxt == DONE) && !sts_fire;
`endif
      if (state == IDLE && cmd_valid) begin
        addr_q <= cmd_dst_addr;
        len_q  <= cmd_mem_length[22:0];
      end
    end
  end

  // Payload packing: word 0 waits in hold_q, word 1 or an end condition loads the output beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q              <= '0;
      len_err_q          <= 1'b0;
      hold_q             <= '0;
      half_q             <= 1'b0;
      in_open_q          <= 1'b0;
      drop_q             <= 1'b0;
      last_sent_q        <= 1'b0;
      m_axis_s2mm_tvalid <= 1'b0;
      m_axis_s2mm_tdata  <= '0;
      m_axis_s2mm_tkeep  <= '0;
      m_axis_s2mm_tlast  <= 1'b0;
    end else begin
      if (state == IDLE && cmd_valid) begin
        cnt_q       <= '0;
        len_err_q   <= 1'b0;
        half_q      <= 1'b0;
        in_open_q   <= 1'b1;
        drop_q      <= 1'b0;
        last_sent_q <= 1'b0;
      end
      if (out_fire) begin
        m_axis_s2mm_tvalid <= 1'b0;
        if (m_axis_s2mm_tlast) last_sent_q <= 1'b1;
      end
      if (in_acc) begin
        if (drop_q) begin
          if (s_axis_tlast) begin
            drop_q    <= 1'b0;
            in_open_q <= 1'b0;
          end
        end else begin
          cnt_q <= cnt_nxt;
          if (s_axis_tlast && !hit_len) len_err_q <= 1'b1;
          if (hit_len && !s_axis_tlast) begin
            len_err_q <= 1'b1;
            drop_q    <= 1'b1;
          end else if (end_w) begin
            in_open_q <= 1'b0;
          end
          if (!half_q) begin
            if (end_w) begin
              m_axis_s2mm_tvalid <= 1'b1;
              m_axis_s2mm_tdata  <= {{IN_WIDTH{1'b0}}, s_axis_tdata};
              m_axis_s2mm_tkeep  <= KEEP_HALF;
              m_axis_s2mm_tlast  <= 1'b1;
            end else begin
              hold_q <= s_axis_tdata;
              half_q <= 1'b1;
            end
          end else begin
            m_axis_s2mm_tvalid <= 1'b1;
            m_axis_s2mm_tdata  <= {s_axis_tdata, hold_q};
            m_axis_s2mm_tkeep  <= KEEP_FULL;
            m_axis_s2mm_tlast  <= end_w;
            half_q             <= 1'b0;
          end
        end
      end
    end
  end

endmodule
